// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the matrix keypad scanner: scan FSM encoding,
// parameter defaults and a constant log2 helper.
package keypad_pkg;
  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_SCAN_DIV   = 50000;
  localparam int DEF_DEB_FRAMES = 4;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic {
    ST_DRIVE   = 1'b0,
    ST_PROCESS = 1'b1
  } scan_state_t;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event stream: head code plus valid/ready handshake.
interface keypad_scanner_if #(
  parameter int POS_W = 4
);
  logic [POS_W-1:0] key_pos;
  logic             key_valid;
  logic             key_ready;

  modport master (output key_pos, output key_valid, input  key_ready);
  modport slave  (input  key_pos, input  key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner_fifo.sv
// First-word-fall-through event queue; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_req,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         drop
);
  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wptr, rptr;
  logic                    empty, full, pop, wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = pop_req && !empty;
  // a pop in the same cycle frees the slot the push lands in
  assign wr    = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign valid = !empty;
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad controller: drives one column low at a time,
// debounces every key across frames and queues press events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int DEB_FRAMES = DEF_DEB_FRAMES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   fila,
  output logic [COLS-1:0]   col,
  keypad_scanner_if.master  ev,
  output logic              held,
  output logic              overflow,
  input  logic              clr_ovf
);
  localparam int NKEYS = ROWS * COLS;
  localparam int POS_W = (clog2(NKEYS) < 1) ? 1 : clog2(NKEYS);
  localparam int RW    = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);
  localparam int CW    = (clog2(COLS) < 1) ? 1 : clog2(COLS);
  localparam int DW    = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
  localparam int CNT_W = (clog2(DEB_FRAMES + 1) < 1) ? 1 : clog2(DEB_FRAMES + 1);

  scan_state_t               state, nxt;
  logic [ROWS-1:0]           fila_s1, fila_s2, samp;
  logic [DW-1:0]             div;
  logic [RW-1:0]             row;
  logic [CW-1:0]             c, c_nxt;
  logic [COLS-1:0]           col_r;
  logic [NKEYS-1:0]          stable;
  logic [NKEYS-1:0][CNT_W-1:0] cnt;
  logic [POS_W-1:0]          idx;
  logic                      div_done, row_last, proc, cur_s, differ, hit, push;
  logic                      held_r, ovf_r, drop;
  logic [POS_W-1:0]          head;
  logic                      valid;

  assign div_done = (div == DW'(SCAN_DIV - 1));
  assign row_last = (row == RW'(ROWS - 1));
  assign c_nxt    = (c == CW'(COLS - 1)) ? '0 : c + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_DRIVE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_DRIVE:   if (div_done) nxt = ST_PROCESS;
      ST_PROCESS: if (row_last) nxt = ST_DRIVE;
      default:    nxt = ST_DRIVE;
    endcase
  end

  // rows idle high, so the synchronizer resets to the released level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fila_s1 <= '1;
      fila_s2 <= '1;
    end else begin
      fila_s1 <= fila;
      fila_s2 <= fila_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div   <= '0;
      row   <= '0;
      c     <= '0;
      col_r <= ~COLS'(1);
      samp  <= '0;
    end else if (state == ST_DRIVE) begin
      if (div_done) begin
        div  <= '0;
        samp <= ~fila_s2;
      end else begin
        div <= div + DW'(1);
      end
    end else begin
      if (row_last) begin
        row   <= '0;
        c     <= c_nxt;
        col_r <= ~(COLS'(1) << c_nxt);
      end else begin
        row <= row + RW'(1);
      end
    end
  end

  assign col    = col_r;
  assign proc   = (state == ST_PROCESS);
  assign idx    = POS_W'(int'(row) * COLS + int'(c));
  assign cur_s  = samp[row];
  assign differ = (cur_s != stable[idx]);
  assign hit    = differ && (cnt[idx] == CNT_W'(DEB_FRAMES - 1));
  assign push   = proc && hit && cur_s;

  // one key per PROCESS cycle; a toggle to pressed emits its code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      cnt    <= '0;
    end else if (proc) begin
      if (!differ) begin
        cnt[idx] <= '0;
      end else if (hit) begin
        stable[idx] <= ~stable[idx];
        cnt[idx]    <= '0;
      end else begin
        cnt[idx] <= cnt[idx] + CNT_W'(1);
      end
    end
  end

  key_fifo #(.W(POS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (idx),
    .pop_req   (ev.key_ready),
    .head      (head),
    .valid     (valid),
    .drop      (drop)
  );

  assign ev.key_pos   = head;
  assign ev.key_valid = valid;

  // a drop in the same cycle as clr_ovf keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      held_r <= |stable;
      if (drop)         ovf_r <= 1'b1;
      else if (clr_ovf) ovf_r <= 1'b0;
    end
  end

  assign held     = held_r;
  assign overflow = ovf_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  fila;
  logic [3:0]  col;
  logic        held, overflow;
  logic        clr_ovf = 1'b0;
  logic [15:0] keys = '0;
  int          passed = 0;
  int          total  = 0;

  keypad_scanner_if #(.POS_W(4)) ev();

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEB_FRAMES(2), .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fila     (fila),
    .col      (col),
    .ev       (ev.master),
    .held     (held),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  // a pressed key pulls its row low while its column is driven low
  always_comb begin
    fila = '1;
    for (int r = 0; r < 4; r++)
      fila[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk) ev.key_ready = 1'b1;
    @(negedge clk) ev.key_ready = 1'b0;
  endtask

  // waits for the next arrival of column pattern v
  task automatic wait_col(input logic [3:0] v);
    int n;
    n = 0;
    while (col == v && n < 100) begin @(negedge clk); n++; end
    while (col != v && n < 100) begin @(negedge clk); n++; end
    check("wait_col_timeout", 32'(n < 100), 32'd1);
  endtask

  logic [3:0] ovf_codes [5] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd3};
  logic [3:0] full_codes[4] = '{4'd2, 4'd7, 4'd8, 4'd13};
  logic [3:0] exp_after [4] = '{4'd7, 4'd8, 4'd13, 4'd1};

  initial begin
    ev.key_ready = 1'b0;
    #23;
    check("rst_col",   32'(col),          32'hE);
    check("rst_valid", 32'(ev.key_valid), 32'd0);
    check("rst_pos",   32'(ev.key_pos),   32'd0);
    check("rst_held",  32'(held),         32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    @(negedge clk) rst = 1'b1;

    // single press of row 2 / column 1
    cyc(5);
    keys[9] = 1'b1;
    cyc(70);
    check("single_valid", 32'(ev.key_valid), 32'd1);
    check("single_pos",   32'(ev.key_pos),   32'd9);
    check("single_held",  32'(held),         32'd1);
    pop();
    check("single_popped", 32'(ev.key_valid), 32'd0);
    cyc(40);
    check("single_once", 32'(ev.key_valid), 32'd0);
    keys[9] = 1'b0;
    cyc(70);
    check("release_valid", 32'(ev.key_valid), 32'd0);
    check("release_held",  32'(held),         32'd0);

    // bounce: key 0 flips between consecutive column-0 samples
    for (int i = 0; i < 8; i++) begin
      wait_col(4'b1101);
      keys[0] = ~keys[0];
      check("bounce_held", 32'(held), 32'd0);
    end
    keys[0] = 1'b0;
    cyc(70);
    check("bounce_valid", 32'(ev.key_valid), 32'd0);
    check("bounce_held_end", 32'(held), 32'd0);

    // two rows of column 2 in the same frame
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    cyc(70);
    check("multi_first", 32'(ev.key_pos), 32'd6);
    pop();
    check("multi_second_valid", 32'(ev.key_valid), 32'd1);
    check("multi_second", 32'(ev.key_pos), 32'd14);
    pop();
    check("multi_empty", 32'(ev.key_valid), 32'd0);
    keys = '0;
    cyc(70);
    check("multi_held_off", 32'(held), 32'd0);

    // overflow: fifth press with nothing consumed is dropped
    for (int i = 0; i < 4; i++) begin
      keys[ovf_codes[i]] = 1'b1;
      cyc(70);
    end
    check("ovf_not_yet", 32'(overflow), 32'd0);
    keys[ovf_codes[4]] = 1'b1;
    cyc(70);
    check("ovf_set",   32'(overflow),     32'd1);
    check("ovf_valid", 32'(ev.key_valid), 32'd1);
    @(negedge clk) clr_ovf = 1'b1;
    @(negedge clk) clr_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", 32'(ev.key_pos), 32'(ovf_codes[i]));
      pop();
    end
    check("ovf_drained", 32'(ev.key_valid), 32'd0);
    keys = '0;
    cyc(70);

    // full FIFO: pop lands on the same edge as a new push
    for (int i = 0; i < 4; i++) begin
      keys[full_codes[i]] = 1'b1;
      cyc(70);
    end
    check("full_head", 32'(ev.key_pos), 32'd2);
    wait_col(4'b1011);
    keys[1] = 1'b1;
    wait_col(4'b1011);
    wait_col(4'b1101);
    cyc(4);
    ev.key_ready = 1'b1;
    @(negedge clk) ev.key_ready = 1'b0;
    cyc(2);
    check("full_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("full_order", 32'(ev.key_pos), 32'(exp_after[i]));
      pop();
    end
    check("full_drained", 32'(ev.key_valid), 32'd0);
    keys = '0;
    cyc(70);

    // asynchronous reset with an event queued and a key held
    keys[9] = 1'b1;
    cyc(70);
    check("pre_rst_valid", 32'(ev.key_valid), 32'd1);
    check("pre_rst_held",  32'(held),         32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_col",   32'(col),          32'hE);
    check("mid_rst_valid", 32'(ev.key_valid), 32'd0);
    check("mid_rst_ovf",   32'(overflow),     32'd0);
    check("mid_rst_held",  32'(held),         32'd0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1 check("restart_col0", 32'(col), 32'hE);
    end
    @(posedge clk);
    #1 check("restart_col1", 32'(col), 32'hD);
    check("restart_valid", 32'(ev.key_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of row inputs.
REQ-002 SHALL have parameter COLS, default 4, number of column drive outputs.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clk cycles each column is driven before sampling; must be at least 4.
REQ-004 SHALL have parameter DEB_FRAMES, default 4, consecutive identical samples that make a key state stable; must be at least 1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, key-event queue depth; must be a power of two, at least 2.
REQ-006 SHALL define local POS_W = clog2(ROWS*COLS), minimum 1.
REQ-007 clk  input  1  single system clock; all state on its rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 fila  input  ROWS  row lines, active-low; asynchronous to clk.
REQ-010 col  output  COLS  column drive, one-cold: the driven column is low, all others high.
REQ-011 key_pos  output  POS_W  code of the head event, row*COLS+column.
REQ-012 key_valid  output  1  FIFO non-empty; key_pos is valid.
REQ-013 key_ready  input  1  consumer accepts the head event.
REQ-014 held  output  1  at least one key is stable-pressed.
REQ-015 overflow  output  1  sticky flag: an event was dropped.
REQ-016 clr_ovf  input  1  clears overflow.

Function
REQ-017 fila SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-018 FSM states: DRIVE and PROCESS.
- DRIVE: holds col with column c low for SCAN_DIV cycles, then latches the synchronized rows into a sample register and enters PROCESS.
REQ-019 PROCESS SHALL take exactly ROWS cycles, handling row r = 0..ROWS-1 in order, one row per cycle.
- On exit: c advances, wrapping COLS-1 -> 0; FSM returns to DRIVE.
REQ-020 Each key SHALL have a stable bit and a counter of width clog2(DEB_FRAMES+1).
- Sample equals stable: counter clears.
- Sample differs: counter increments.
- When the counter reaches DEB_FRAMES: stable toggles and the counter clears.
REQ-021 A stable 0->1 (press) transition SHALL push key code r*COLS+c in the same cycle; a release SHALL push nothing.
REQ-022 The FIFO SHALL be first-word-fall-through: key_valid = not empty; key_pos = head; pop on key_valid && key_ready.
REQ-023 Full, push without pop: push is dropped and overflow is set next cycle.
- Full with push and pop in the same cycle: both accepted.
- Empty: key_ready has no effect.
REQ-024 overflow SHALL remain set until clr_ovf=1. If clr_ovf and a drop occur in the same cycle, set wins.
REQ-025 held SHALL be the registered OR of all stable bits.
REQ-026 Scan period per frame SHALL be COLS*(SCAN_DIV+ROWS) cycles.

Reset
REQ-027 While rst=0, all state SHALL clear asynchronously:
- FSM in DRIVE, c=0, col=~1 (column 0 low), divider 0;
- stable bits and counters 0, FIFO empty;
- key_valid=0, key_pos=0, held=0, overflow=0.
REQ-028 Reset asserted mid-PROCESS or mid-FIFO-access SHALL discard all events.
- After release, scanning restarts at column 0 with a full SCAN_DIV period.

Structure
REQ-029 Shared package keypad_pkg SHALL hold:
- the FSM state encoding;
- the clog2 function;
- parameter default constants.
REQ-030 The FIFO SHALL be a sub-module key_fifo, parametrised by width POS_W and depth FIFO_DEPTH.
- It owns the full/empty logic and pointers with one extra wrap bit.

Verification
All scenarios use ROWS=4, COLS=4, SCAN_DIV=4, DEB_FRAMES=2, FIFO_DEPTH=4.
REQ-031 Reset: rst=0 mid-scan -> col=4'b1110, key_valid=0, overflow=0, held=0 immediately; first column change 8 cycles after release.
REQ-032 Single press: row 2 held low while column 1 is driven, for 2 frames -> exactly one event key_pos=9, held=1; release produces no event and held=0.
REQ-033 Bounce: row 0 on column 0 toggles every frame -> no event, held stays 0.
REQ-034 Multi-key: rows 1 and 3 of column 2 pressed in the same frame -> events 6 then 14, in that order.
REQ-035 Overflow: 5 distinct presses with key_ready=0 -> FIFO holds the first 4, overflow=1; clr_ovf=1 -> overflow=0; 4 pops return the codes in press order.
REQ-036 Full push+pop: FIFO full, key_ready=1 in the same cycle as a new press -> no drop, overflow stays 0, count stays 4.
